// File: rtl/dpmem_pkg.sv
// dpmem_pkg: shared types and parameter checks for the simple dual-port RAM blocks.
package dpmem_pkg;

  typedef enum logic {CLEAR, RUN} state_e;

  function automatic bit lat_ok(input int lat);
    return lat == 1 || lat == 2;
  endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// sdp_ram_core: bare byte-enabled storage array with a registered read port, no reset.
module sdp_ram_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int BYTE_W = 8,
  parameter int NB     = DATA_W / BYTE_W,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [NB-1:0]     wbe_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (we_i && wbe_i[b]) mem_q[waddr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sdp_ram_pipe.sv
// sdp_ram_pipe: single-clock simple dual-port RAM with clear sequencer, bypass and 1/2-cycle read pipe.
module sdp_ram_pipe import dpmem_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 32,
  parameter int BYTE_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int BYPASS     = 1,
  parameter int INIT_CLEAR = 1,
  parameter int NB         = DATA_W / BYTE_W,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NB-1:0]     wr_be,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  generate
    if (!lat_ok(RD_LAT) || (DATA_W % BYTE_W) != 0) begin : g_bad_cfg
      $error("sdp_ram_pipe: RD_LAT must be 1 or 2 and DATA_W a multiple of BYTE_W");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              ready_q;
  logic              wr_in, rd_in, wr_fire, rd_fire, clr;
  logic [NB-1:0]     bm_d, bm1_q;
  logic [DATA_W-1:0] bd1_q, core_q, rd1, rd2_q;
  logic              v1_q, v2_q, zero1_q;

  assign wr_in   = {1'b0, wr_addr} < DEPTH_C;
  assign rd_in   = {1'b0, rd_addr} < DEPTH_C;
  assign wr_fire = ready_q && wr_en && wr_in && !rst;
  assign rd_fire = ready_q && rd_en && !rst;
  assign clr     = state_q == CLEAR && !rst;

  always_comb begin
    cnt_d   = clr ? cnt_q + AW'(1) : cnt_q;
    state_d = (clr && cnt_q == LAST) ? RUN : state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_CLEAR != 0) ? CLEAR : RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= state_q == RUN;
    end
  end

  sdp_ram_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BYTE_W(BYTE_W), .NB(NB), .AW(AW)) u_core (
    .clk    (clk),
    .we_i   (clr || wr_fire),
    .waddr_i(clr ? cnt_q : wr_addr),
    .wdata_i(clr ? '0 : wr_data),
    .wbe_i  (clr ? '1 : wr_be),
    .re_i   (rd_fire && rd_in),
    .raddr_i(rd_addr),
    .rdata_o(core_q)
  );

  // The array returns the old word; lanes written in the read cycle are patched in afterwards.
  assign bm_d = (BYPASS != 0 && wr_fire && wr_addr == rd_addr) ? wr_be : '0;

  always_ff @(posedge clk) begin
    v1_q <= rd_fire;
    v2_q <= !rst && v1_q;
    if (rst) zero1_q <= 1'b1;
    else if (rd_fire) zero1_q <= !rd_in;
    if (rd_fire) begin
      bm1_q <= bm_d;
      bd1_q <= wr_data;
    end
    if (rst) rd2_q <= '0;
    else if (v1_q) rd2_q <= rd1;
  end

  always_comb begin
    rd1 = '0;
    for (int b = 0; b < NB; b++)
      rd1[b*BYTE_W +: BYTE_W] = zero1_q ? '0 : bm1_q[b] ? bd1_q[b*BYTE_W +: BYTE_W] : core_q[b*BYTE_W +: BYTE_W];
  end

  assign ready    = ready_q;
  assign rd_data  = (RD_LAT == 2) ? rd2_q : rd1;
  assign rd_valid = (RD_LAT == 2) ? v2_q : v1_q;

endmodule
